// File: rtl/verinject_random_tester_pkg.sv
// Shared constants, FSM encoding and LFSR helpers for the verinject testers and monitor.
// Imported by verinject_lfsr32 and verinject_random_tester.
package verinject_random_tester_pkg;

    localparam logic [31:0] VERINJECT_IDLE_STATE = 32'hFFFF_FFFF;
    localparam logic [31:0] VERINJECT_LFSR_TAPS  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_INJECT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? VERINJECT_LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/verinject_lfsr32.sv
// 32-bit Galois LFSR; loads the (zero-protected) seed on reset and steps while enabled.
module verinject_lfsr32
    import verinject_random_tester_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] value_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= lfsr_seed(seed);
        end else if (enable) begin
            value_q <= lfsr_step(value_q);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/verinject_random_tester.sv
// Pseudo-random single-bit fault-injection driver with a free-running 48-bit cycle timebase.
// Define VERINJECT_RANDOM_LOG_EN to print every injection and the campaign completion.
module verinject_random_tester
    import verinject_random_tester_pkg::*;
#(
    parameter int unsigned TOTAL_BITS     = 96,
    parameter logic [31:0] SEED           = 32'hACE1_2345,
    parameter int unsigned MIN_GAP        = 4,
    parameter int unsigned GAP_MASK       = 15,
    parameter int unsigned NUM_INJECTIONS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] verinject__injector_state,
    output logic [47:0] cycle_number,
    output logic [15:0] inject_count
);

    localparam int unsigned IDX_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam logic [15:0] MIN_GAP_W  = 16'(MIN_GAP);
    localparam logic [7:0]  GAP_MASK_W = 8'(GAP_MASK);
    localparam logic [15:0] NUM_W      = 16'(NUM_INJECTIONS);

    state_e      state_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] inj_q;
    logic [47:0] cycle_q;
    logic [15:0] count_q;
    logic [15:0] gap_q;

    logic        lfsr_en;
    logic [31:0] lfsr_value;
    logic [31:0] idx_d;
    logic [15:0] gap_d;
    logic [15:0] count_d;
    logic        last_d;
    logic        lfsr_unused;

    assign lfsr_en = (state_q == ST_WAIT) || (state_q == ST_INJECT);

    verinject_lfsr32 u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (lfsr_en),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    // The low IDX_W bits span less than 2*TOTAL_BITS, so one subtraction folds them into range.
    always_comb begin
        idx_d = 32'(lfsr_value[IDX_W-1:0]);
        if (idx_d >= TOTAL_BITS) begin
            idx_d = idx_d - TOTAL_BITS;
        end
    end

    assign gap_d       = MIN_GAP_W + {8'd0, lfsr_value[23:16] & GAP_MASK_W};
    assign count_d     = count_q + 16'd1;
    assign last_d      = (count_d == NUM_W);
    assign lfsr_unused = ^lfsr_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 48'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inj_q   <= VERINJECT_IDLE_STATE;
            count_q <= '0;
            gap_q   <= '0;
        end else begin
            inj_q <= VERINJECT_IDLE_STATE;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        count_q <= '0;
                        gap_q   <= MIN_GAP_W;
                        if (NUM_W == 16'd0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    gap_q <= gap_q - 16'd1;
                    if (gap_q <= 16'd1) begin
                        state_q <= ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    inj_q   <= idx_d;
                    count_q <= count_d;
                    if (last_d) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        gap_q   <= gap_d;
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VERINJECT_RANDOM_LOG_EN
    always_ff @(posedge clock) begin
        if (reset_n && state_q == ST_INJECT) begin
            $display("verinject: cycle %0d bit %0d", cycle_q, idx_d);
            if (last_d) begin
                $display("verinject: campaign done, %0d injections", count_d);
            end
        end
        if (reset_n && start && NUM_W == 16'd0 && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            $display("verinject: campaign done, %0d injections", 0);
        end
    end
`endif

    assign busy                      = busy_q;
    assign done                      = done_q;
    assign verinject__injector_state = inj_q;
    assign cycle_number              = cycle_q;
    assign inject_count              = count_q;

endmodule
